// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - two-port writeback arbiter feeding the GPR file write port
// REGWR_ARB_RR_EN selects round-robin arbitration; undefined gives fixed priority to port 0.
module regfile_wr_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          CLK_I,
  input  logic          RSTN_I,
  input  logic          REQ0_VALID_I,
  input  logic [AW-1:0] REQ0_RD_I,
  input  logic [DW-1:0] REQ0_DATA_I,
  output logic          REQ0_READY_O,
  input  logic          REQ1_VALID_I,
  input  logic [AW-1:0] REQ1_RD_I,
  input  logic [DW-1:0] REQ1_DATA_I,
  output logic          REQ1_READY_O,
  input  logic          FLUSH_I,
  output logic [AW-1:0] RD_O,
  output logic          RegWr_O,
  output logic [DW-1:0] WData_O,
  output logic [31:0]   BUSY_O,
  output logic          IDLE_O
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] rd_mem   [2][DEPTH];
  logic [DW-1:0] data_mem [2][DEPTH];
  logic [PW-1:0] wr_ptr   [2];
  logic [PW-1:0] rd_ptr   [2];
  logic [CW-1:0] cnt      [2];

  logic [1:0]    req_valid;
  logic [AW-1:0] req_rd   [2];
  logic [DW-1:0] req_data [2];
  logic [1:0]    ready;
  logic [1:0]    push;
  logic [1:0]    non_empty;
  logic [1:0]    gnt;
  logic [31:0]   busy;

  assign req_valid   = {REQ1_VALID_I, REQ0_VALID_I};
  assign req_rd[0]   = REQ0_RD_I;
  assign req_rd[1]   = REQ1_RD_I;
  assign req_data[0] = REQ0_DATA_I;
  assign req_data[1] = REQ1_DATA_I;

  // Writes to GPR0 complete the handshake but are never queued.
  always_comb begin
    ready     = '0;
    push      = '0;
    non_empty = '0;
    for (int p = 0; p < 2; p++) begin
      ready[p]     = cnt[p] < FULL_CNT;
      push[p]      = req_valid[p] & ready[p] & (req_rd[p] != '0) & !FLUSH_I;
      non_empty[p] = cnt[p] != '0;
    end
  end

  assign REQ0_READY_O = ready[0];
  assign REQ1_READY_O = ready[1];

`ifdef REGWR_ARB_RR_EN
  logic last_gnt1;

  assign gnt[0] = !FLUSH_I & non_empty[0] & (!non_empty[1] | last_gnt1);

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      last_gnt1 <= 1'b1;
    end else if (gnt[0]) begin
      last_gnt1 <= 1'b0;
    end else if (gnt[1]) begin
      last_gnt1 <= 1'b1;
    end
  end
`else
  assign gnt[0] = !FLUSH_I & non_empty[0];
`endif
  assign gnt[1] = !FLUSH_I & non_empty[1] & !gnt[0];

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      for (int p = 0; p < 2; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        cnt[p]    <= '0;
      end
    end else if (FLUSH_I) begin
      for (int p = 0; p < 2; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        cnt[p]    <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + PW'(1);
        if (gnt[p])  rd_ptr[p] <= rd_ptr[p] + PW'(1);
        cnt[p] <= cnt[p] + CW'(push[p]) - CW'(gnt[p]);
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) begin
        rd_mem[p][wr_ptr[p]]   <= req_rd[p];
        data_mem[p][wr_ptr[p]] <= req_data[p];
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      RegWr_O <= 1'b0;
      RD_O    <= '0;
      WData_O <= '0;
    end else if (gnt[0]) begin
      RegWr_O <= 1'b1;
      RD_O    <= rd_mem[0][rd_ptr[0]];
      WData_O <= data_mem[0][rd_ptr[0]];
    end else if (gnt[1]) begin
      RegWr_O <= 1'b1;
      RD_O    <= rd_mem[1][rd_ptr[1]];
      WData_O <= data_mem[1][rd_ptr[1]];
    end else begin
      RegWr_O <= 1'b0;
    end
  end

  // Only the first cnt entries after the read pointer hold live writes.
  always_comb begin
    busy = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) < cnt[p]) busy[rd_mem[p][rd_ptr[p] + PW'(i)]] = 1'b1;
      end
    end
    if (RegWr_O) busy[RD_O] = 1'b1;
    busy[0] = 1'b0;
  end

  assign BUSY_O = busy;
  assign IDLE_O = !non_empty[0] & !non_empty[1] & !RegWr_O;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

  logic        CLK_I = 1'b0;
  logic        RSTN_I;
  logic        REQ0_VALID_I;
  logic [4:0]  REQ0_RD_I;
  logic [31:0] REQ0_DATA_I;
  logic        REQ0_READY_O;
  logic        REQ1_VALID_I;
  logic [4:0]  REQ1_RD_I;
  logic [31:0] REQ1_DATA_I;
  logic        REQ1_READY_O;
  logic        FLUSH_I;
  logic [4:0]  RD_O;
  logic        RegWr_O;
  logic [31:0] WData_O;
  logic [31:0] BUSY_O;
  logic        IDLE_O;

  int n_err = 0;
  int n_chk = 0;
  logic [4:0] exp_ord [4];

  regfile_wr_arbiter #(.DEPTH(2), .AW(5), .DW(32)) dut (
    .CLK_I(CLK_I), .RSTN_I(RSTN_I),
    .REQ0_VALID_I(REQ0_VALID_I), .REQ0_RD_I(REQ0_RD_I), .REQ0_DATA_I(REQ0_DATA_I),
    .REQ0_READY_O(REQ0_READY_O),
    .REQ1_VALID_I(REQ1_VALID_I), .REQ1_RD_I(REQ1_RD_I), .REQ1_DATA_I(REQ1_DATA_I),
    .REQ1_READY_O(REQ1_READY_O),
    .FLUSH_I(FLUSH_I), .RD_O(RD_O), .RegWr_O(RegWr_O), .WData_O(WData_O),
    .BUSY_O(BUSY_O), .IDLE_O(IDLE_O)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic idle_inputs();
    REQ0_VALID_I = 1'b0; REQ0_RD_I = '0; REQ0_DATA_I = '0;
    REQ1_VALID_I = 1'b0; REQ1_RD_I = '0; REQ1_DATA_I = '0;
    FLUSH_I = 1'b0;
  endtask

  task automatic do_reset();
    RSTN_I = 1'b0;
    idle_inputs();
    tick();
    tick();
    RSTN_I = 1'b1;
  endtask

  task automatic expect_write(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check({tag, "_wr"}, 64'(RegWr_O), 64'd1);
    check({tag, "_rd"}, 64'(RD_O), 64'(rd));
    check({tag, "_data"}, 64'(WData_O), 64'(data));
  endtask

  initial begin
    RSTN_I = 1'b0;
    idle_inputs();
    #3;
    check("rst_regwr", 64'(RegWr_O), 64'd0);
    check("rst_rd", 64'(RD_O), 64'd0);
    check("rst_wdata", 64'(WData_O), 64'd0);
    check("rst_busy", 64'(BUSY_O), 64'd0);
    check("rst_idle", 64'(IDLE_O), 64'd1);
    check("rst_ready0", 64'(REQ0_READY_O), 64'd1);
    check("rst_ready1", 64'(REQ1_READY_O), 64'd1);
    do_reset();

    // Single write: accepted at E0, staged at E1.
    REQ0_VALID_I = 1'b1; REQ0_RD_I = 5'd5; REQ0_DATA_I = 32'hDEADBEEF;
    tick();
    idle_inputs();
    check("sw_e0_regwr", 64'(RegWr_O), 64'd0);
    check("sw_e0_busy", 64'(BUSY_O), 64'h20);
    check("sw_e0_idle", 64'(IDLE_O), 64'd0);
    tick();
    expect_write("sw_e1", 5'd5, 32'hDEADBEEF);
    check("sw_e1_busy", 64'(BUSY_O), 64'h20);
    tick();
    check("sw_e2_regwr", 64'(RegWr_O), 64'd0);
    check("sw_e2_busy", 64'(BUSY_O), 64'd0);
    check("sw_e2_idle", 64'(IDLE_O), 64'd1);
    check("sw_e2_rd_hold", 64'(RD_O), 64'd5);

    // rd = 0 is accepted and discarded.
    REQ0_VALID_I = 1'b1; REQ0_RD_I = 5'd0; REQ0_DATA_I = 32'h1234;
    check("z_ready", 64'(REQ0_READY_O), 64'd1);
    tick();
    idle_inputs();
    check("z_ready_after", 64'(REQ0_READY_O), 64'd1);
    check("z_busy", 64'(BUSY_O), 64'd0);
    check("z_idle", 64'(IDLE_O), 64'd1);
    check("z_regwr0", 64'(RegWr_O), 64'd0);
    tick();
    check("z_regwr1", 64'(RegWr_O), 64'd0);
    check("z_idle1", 64'(IDLE_O), 64'd1);

    // Tie ordering from a fresh reset.
    do_reset();
`ifdef REGWR_ARB_RR_EN
    exp_ord[0] = 5'd1; exp_ord[1] = 5'd3; exp_ord[2] = 5'd2; exp_ord[3] = 5'd4;
`else
    exp_ord[0] = 5'd1; exp_ord[1] = 5'd2; exp_ord[2] = 5'd3; exp_ord[3] = 5'd4;
`endif
    REQ0_VALID_I = 1'b1; REQ0_RD_I = 5'd1; REQ0_DATA_I = 32'h11;
    REQ1_VALID_I = 1'b1; REQ1_RD_I = 5'd3; REQ1_DATA_I = 32'h33;
    tick();
    REQ0_RD_I = 5'd2; REQ0_DATA_I = 32'h22;
    REQ1_RD_I = 5'd4; REQ1_DATA_I = 32'h44;
    tick();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      expect_write($sformatf("tie%0d", k), exp_ord[k], 32'({27'd0, exp_ord[k]}) * 32'h11);
      tick();
    end
    check("tie_end_regwr", 64'(RegWr_O), 64'd0);
    check("tie_end_idle", 64'(IDLE_O), 64'd1);

`ifndef REGWR_ARB_RR_EN
    // Backpressure: port 0 refilled every cycle starves port 1.
    REQ0_VALID_I = 1'b1; REQ0_RD_I = 5'd7; REQ0_DATA_I = 32'h7777;
    REQ1_VALID_I = 1'b1; REQ1_RD_I = 5'd10; REQ1_DATA_I = 32'hA0A0;
    tick();
    REQ1_RD_I = 5'd11; REQ1_DATA_I = 32'hB1B1;
    tick();
    check("bp_ready1_full", 64'(REQ1_READY_O), 64'd0);
    expect_write("bp_p0a", 5'd7, 32'h7777);
    REQ1_RD_I = 5'd12; REQ1_DATA_I = 32'hC2C2;
    tick();
    check("bp_ready1_hold", 64'(REQ1_READY_O), 64'd0);
    expect_write("bp_p0b", 5'd7, 32'h7777);
    tick();
    check("bp_ready1_hold2", 64'(REQ1_READY_O), 64'd0);
    check("bp_busy", 64'(BUSY_O), 64'h0C80);
    REQ0_VALID_I = 1'b0;
    tick();
    expect_write("bp_p0c", 5'd7, 32'h7777);
    tick();
    expect_write("bp_r10", 5'd10, 32'hA0A0);
    check("bp_ready1_free", 64'(REQ1_READY_O), 64'd1);
    tick();
    idle_inputs();
    expect_write("bp_r11", 5'd11, 32'hB1B1);
    tick();
    expect_write("bp_r12", 5'd12, 32'hC2C2);
    tick();
    check("bp_end_regwr", 64'(RegWr_O), 64'd0);
    check("bp_end_idle", 64'(IDLE_O), 64'd1);
`endif

    // Flush with a simultaneous push.
    do_reset();
    REQ0_VALID_I = 1'b1; REQ0_RD_I = 5'd1; REQ0_DATA_I = 32'h1;
    REQ1_VALID_I = 1'b1; REQ1_RD_I = 5'd3; REQ1_DATA_I = 32'h3;
    tick();
    REQ0_RD_I = 5'd2; REQ0_DATA_I = 32'h2;
    REQ1_RD_I = 5'd4; REQ1_DATA_I = 32'h4;
    tick();
    check("fl_pre_busy", 64'(BUSY_O), 64'h1E);
    expect_write("fl_pre", 5'd1, 32'h1);
    idle_inputs();
    FLUSH_I = 1'b1;
    REQ0_VALID_I = 1'b1; REQ0_RD_I = 5'd9; REQ0_DATA_I = 32'h9;
    tick();
    idle_inputs();
    check("fl_regwr", 64'(RegWr_O), 64'd0);
    check("fl_busy", 64'(BUSY_O), 64'd0);
    check("fl_idle", 64'(IDLE_O), 64'd1);
    check("fl_ready0", 64'(REQ0_READY_O), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("fl_quiet%0d", k), 64'(RegWr_O), 64'd0);
    end

    // Async reset while a write is staged.
    do_reset();
    REQ0_VALID_I = 1'b1; REQ0_RD_I = 5'd6; REQ0_DATA_I = 32'h66;
    tick();
    idle_inputs();
    tick();
    expect_write("ar_pre", 5'd6, 32'h66);
    #2;
    RSTN_I = 1'b0;
    #1;
    check("ar_regwr", 64'(RegWr_O), 64'd0);
    check("ar_rd", 64'(RD_O), 64'd0);
    check("ar_wdata", 64'(WData_O), 64'd0);
    check("ar_busy", 64'(BUSY_O), 64'd0);
    check("ar_idle", 64'(IDLE_O), 64'd1);
    #3;
    RSTN_I = 1'b1;
    REQ0_VALID_I = 1'b1; REQ0_RD_I = 5'd1; REQ0_DATA_I = 32'hA1;
    REQ1_VALID_I = 1'b1; REQ1_RD_I = 5'd2; REQ1_DATA_I = 32'hB2;
    tick();
    idle_inputs();
    tick();
    expect_write("ar_first", 5'd1, 32'hA1);
    tick();
    expect_write("ar_second", 5'd2, 32'hB2);
    tick();
    check("ar_end_idle", 64'(IDLE_O), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
